lopd_norm_seq: RTL and testbench



---
 rtl/lopd_norm_seq.sv | 146 ++++++++++++++
 tb/tb_lopd_norm_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lopd_norm_seq.sv
// lopd_norm_seq: multi-cycle mantissa normalizer.
// Scans a DATA_W-bit operand one 16-bit chunk per cycle, MSB chunk first, through
// a single shared leading-one detector. It then left-shifts the operand once so
// that its MSB is 1.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_valid/o_ready      operand handshake (o_ready is high only in IDLE)
//   i_data               operand to normalize
//   o_valid/i_ready      result handshake (o_valid is high only in DONE)
//   o_data               i_data << o_lz_count (zero for a zero operand)
//   o_lz_count           leading-zero count, 0..DATA_W
//   o_zero_flag          operand was all zeros
//   o_busy               block is not idle

// lopd_16bit: leading-one position detector for a 16-bit word.
//   d     input word
//   pos   bit index of the most significant 1 (15 = MSB); 0 when d is zero
//   zero  d is all zeros
module lopd_16bit (
  input  logic [15:0] d,
  output logic [3:0]  pos,
  output logic        zero
);

  always_comb begin
    pos = '0;
    // Later iterations win, so the highest set bit determines pos.
    for (int unsigned i = 0; i < 16; i++) begin
      if (d[i]) pos = 4'(i);
    end
  end

  assign zero = ~|d;

endmodule

module lopd_norm_seq #(
  parameter int DATA_W = 48,
  parameter int CHUNKS = DATA_W / 16,
  parameter int LZ_W   = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [LZ_W-1:0]   o_lz_count,
  output logic              o_zero_flag,
  output logic              o_busy
);

  localparam int KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] opnd;
  logic [KW-1:0]     k;
  logic [LZ_W-1:0]   lz;

  logic [15:0]       chunk;
  logic [3:0]        lopd_pos;
  logic              lopd_zero;
  logic [LZ_W-1:0]   lz_scan;

  // A mux over constant part-selects avoids a variable-width shift of the
  // whole operand just to reach one chunk.
  always_comb begin
    chunk = '0;
    for (int unsigned c = 0; c < CHUNKS; c++) begin
      if (k == KW'(c)) chunk = opnd[DATA_W-1-16*c -: 16];
    end
  end

  lopd_16bit u_lopd (
    .d    (chunk),
    .pos  (lopd_pos),
    .zero (lopd_zero)
  );

  // lz = 16k + (15 - pos); 16k is the chunk index with four zero bits appended.
  assign lz_scan = LZ_W'({k, 4'b0000}) + LZ_W'(4'd15 - lopd_pos);

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      opnd        <= '0;
      k           <= '0;
      lz          <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_lz_count  <= '0;
      o_zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            opnd  <= i_data;
            k     <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!lopd_zero) begin
            lz    <= lz_scan;
            state <= SHIFT;
          end else if (k == KW'(CHUNKS - 1)) begin
            o_data      <= '0;
            o_lz_count  <= LZ_W'(DATA_W);
            o_zero_flag <= 1'b1;
            o_valid     <= 1'b1;
            state       <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        SHIFT: begin
          o_data      <= opnd << lz;
          o_lz_count  <= lz;
          o_zero_flag <= 1'b0;
          o_valid     <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lopd_norm_seq.sv
module tb_lopd_norm_seq;

  localparam int DATA_W = 48;
  localparam int LZ_W   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              in_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [LZ_W-1:0]   out_lz;
  logic              out_zero;
  logic              busy;

  lopd_norm_seq #(.DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (in_valid),
    .o_ready     (out_ready),
    .i_data      (in_data),
    .o_valid     (out_valid),
    .i_ready     (in_ready),
    .o_data      (out_data),
    .o_lz_count  (out_lz),
    .o_zero_flag (out_zero),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [LZ_W-1:0]   lz;
    logic              zero;
    int                lat;
    int                acc;
  } item_t;

  item_t sb[$];
  int total = 0;
  int bad = 0;
  bit seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each result once, on the first cycle it is presented.
  always @(negedge clk) begin
    if (!out_valid) begin
      seen = 0;
    end else if (!seen) begin
      seen = 1;
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(out_data), 64'hDEAD);
      end else begin
        item_t it;
        it = sb.pop_front();
        check("o_data", 64'(out_data), 64'(it.data));
        check("o_lz_count", 64'(out_lz), 64'(it.lz));
        check("o_zero_flag", 64'(out_zero), 64'(it.zero));
        check("latency", 64'(cyc - it.acc), 64'(it.lat));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!out_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 64'(out_ready), 64'd1);
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] ed,
                      input logic [LZ_W-1:0] elz, input logic ez, input int lat);
    item_t it;
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    it.data = ed; it.lz = elz; it.zero = ez; it.lat = lat; it.acc = cyc;
    sb.push_back(it);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(out_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_lz", 64'(out_lz), 64'd0);
    check("rst_zero", 64'(out_zero), 64'd0);
    rst = 1'b0;

    send(48'h8000_0000_0000, 48'h8000_0000_0000, 6'd0, 1'b0, 2);
    send(48'h0000_0000_0001, 48'h8000_0000_0000, 6'd47, 1'b0, 4);
    send(48'h0000_0123_4567, 48'h91A2_B380_0000, 6'd23, 1'b0, 3);
    send(48'h0000_0000_0000, 48'h0000_0000_0000, 6'd48, 1'b1, 3);
    send(48'h00F0_0000_0000, 48'hF000_0000_0000, 6'd8, 1'b0, 2);
    send(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 6'd0, 1'b0, 2);
    send(48'h0000_0001_0000, 48'h8000_0000_0000, 6'd31, 1'b0, 3);

    // Backpressure: hold the result while a new operand is offered.
    wait_ready();
    in_ready = 1'b0;
    send(48'h0000_0000_0001, 48'h8000_0000_0000, 6'd47, 1'b0, 4);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("valid_timeout", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    in_data  = 48'hFFFF_0000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'h8000_0000_0000);
      check("bp_lz", 64'(out_lz), 64'd47);
      check("bp_ready", 64'(out_ready), 64'd0);
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_back", 64'(out_ready), 64'd1);
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    send(48'h0000_0000_8000, 48'h8000_0000_0000, 6'd32, 1'b0, 4);

    // Asynchronous reset during SCAN.
    wait_ready();
    in_valid = 1'b1;
    in_data  = 48'h0000_0000_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(out_ready), 64'd1);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_lz", 64'(out_lz), 64'd0);
    check("arst_zero", 64'(out_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    send(48'h0000_0000_0001, 48'h8000_0000_0000, 6'd47, 1'b0, 4);

    // Drain.
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 64'(sb.size()), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
